// File: rtl/seq_divider_hs.sv
// seq_divider_hs: multi-cycle restoring divider with valid/ready handshakes.
// One quotient bit is produced per CALC cycle, MSB first. Operands are reduced
// to magnitudes at the accept edge. Signs are applied in a single FIX cycle.
// A zero divisor bypasses the iteration and reports div0.
module seq_divider_hs #(
    parameter int DVD_W     = 8,
    parameter int DVS_W     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] in_dividend,
    input  logic [DVS_W-1:0] in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] out_quotient,
    output logic [DVS_W-1:0] out_remainder,
    output logic             out_div0
);

    localparam int CNT_W = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Iteration datapath: dvd_sh starts as the dividend magnitude and fills
    // with quotient bits from the right as dividend bits leave on the left.
    logic [DVD_W-1:0] dvd_sh;
    logic [DVS_W:0]   dvs_mag;
    logic [DVS_W:0]   prem;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             signed_op;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] trial;
    logic             trial_ok;

    // Conditional two's-complement negation at dividend/quotient width.
    function automatic logic [DVD_W-1:0] cneg_dvd(input logic [DVD_W-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    // Divisor magnitude in DVS_W+1 bits so the most-negative divisor's
    // magnitude (e.g. 8 for a 4-bit -8) is representable.
    function automatic logic [DVS_W:0] abs_dvs(input logic [DVS_W-1:0] v,
                                               input logic n);
        logic [DVS_W:0] e;
        e = {n & v[DVS_W-1], v};
        return n ? -e : e;
    endfunction

    // Conditional two's-complement negation at remainder width.
    function automatic logic [DVS_W-1:0] cneg_rem(input logic [DVS_W-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    assign accept    = in_valid && in_ready;
    assign signed_op = SIGNED_EN && in_signed;
    assign dvd_neg   = signed_op && in_dividend[DVD_W-1];
    assign dvs_neg   = signed_op && in_divisor[DVS_W-1];
    assign dvs_zero  = (in_divisor == '0);

    // Restoring step: shift in the next dividend bit, trial-subtract the
    // divisor magnitude; a clear top bit means the subtraction is kept.
    assign shifted  = {prem, dvd_sh[DVD_W-1]};
    assign trial    = shifted - {1'b0, dvs_mag};
    assign trial_ok = ~trial[DVS_W+1];

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (dvs_zero) begin
                            out_quotient  <= '1;
                            out_remainder <= '0;
                            out_div0      <= 1'b1;
                            out_valid     <= 1'b1;
                            state         <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_quotient  <= cneg_dvd(dvd_sh, q_neg);
                    out_remainder <= cneg_rem(prem[DVS_W-1:0], r_neg);
                    out_div0      <= 1'b0;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture at accept, then one restoring iteration per CALC cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            dvd_sh  <= cneg_dvd(in_dividend, dvd_neg);
            dvs_mag <= abs_dvs(in_divisor, dvs_neg);
            prem    <= '0;
            q_neg   <= dvd_neg ^ dvs_neg;
            r_neg   <= dvd_neg;
        end else if (state == CALC) begin
            prem   <= trial_ok ? trial[DVS_W:0] : shifted[DVS_W:0];
            dvd_sh <= {dvd_sh[DVD_W-2:0], trial_ok};
        end
    end

endmodule

// File: tb/tb_seq_divider_hs.sv
// Directed testbench for seq_divider_hs at DVD_W=8, DVS_W=4, SIGNED_EN=1.
module tb_seq_divider_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [3:0] in_divisor;
    logic       in_signed;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quotient;
    logic [3:0] out_remainder;
    logic       out_div0;

    int total = 0;
    int bad   = 0;
    int edges;
    int stray;

    seq_divider_hs #(.DVD_W(8), .DVS_W(4), .SIGNED_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_signed     (in_signed),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div0      (out_div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge; they are accepted at the next posedge.
    task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs, input logic sgn);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        in_valid    = 1'b1;
        in_dividend = dvd;
        in_divisor  = dvs;
        in_signed   = sgn;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge (counted as 1) until out_valid rises.
    task automatic wait_result(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // One-cycle handoff, then confirm the result is gone and input reopens.
    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [7:0] dvd, input logic [3:0] dvs,
                       input logic sgn, input int lat, input logic [7:0] q,
                       input logic [3:0] r, input logic d0);
        int n;
        start_op(dvd, dvs, sgn);
        wait_result(n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_q"}, out_quotient, q);
        check({tag, "_r"}, out_remainder, r);
        check({tag, "_div0"}, out_div0, d0);
        take(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_signed   = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_q", out_quotient, 8'h00);
        check("rst_r", out_remainder, 4'h0);
        check("rst_div0", out_div0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Unsigned and signed quotients, latency inclusive of accept edge.
        run("u100_7",   8'd100, 4'd7, 1'b0, 10, 8'h0E, 4'h2, 1'b0);
        run("sm100_7",  8'h9C,  4'd7, 1'b1, 10, 8'hF2, 4'hE, 1'b0);
        run("s100_m8",  8'd100, 4'h8, 1'b1, 10, 8'hF4, 4'h4, 1'b0);
        run("sm7_2",    8'hF9,  4'd2, 1'b1, 10, 8'hFD, 4'hF, 1'b0);
        run("div0",     8'd13,  4'd0, 1'b0, 1,  8'hFF, 4'h0, 1'b1);
        run("u15_3",    8'd15,  4'd3, 1'b0, 10, 8'h05, 4'h0, 1'b0);
        run("s_ovf",    8'h80,  4'hF, 1'b1, 10, 8'h80, 4'h0, 1'b0);
        run("uFF_1",    8'hFF,  4'd1, 1'b0, 10, 8'hFF, 4'h0, 1'b0);

        // Backpressure: result held, input closed, new request ignored.
        start_op(8'd50, 4'd6, 1'b0);
        wait_result(edges);
        check("bp_lat", edges, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = 8'd99;
            in_divisor  = 4'd5;
            in_signed   = 1'b0;
            check("bp_valid", out_valid, 1'b1);
            check("bp_q", out_quotient, 8'h08);
            check("bp_r", out_remainder, 4'h2);
            check("bp_div0", out_div0, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take("bp");
        @(negedge clk);
        check("bp_single", out_valid, 1'b0);
        run("u7_2", 8'd7, 4'd2, 1'b0, 10, 8'h03, 4'h1, 1'b0);

        // Asynchronous reset part-way through CALC.
        start_op(8'd77, 4'd5, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_q", out_quotient, 8'h00);
        check("mid_rst_r", out_remainder, 4'h0);
        check("mid_rst_div0", out_div0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("mid_rst_stale", stray, 0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        run("u200_9", 8'd200, 4'd9, 1'b0, 10, 8'h16, 4'h2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
